// File: rtl/mesh_boot_sequencer.sv
// mesh_boot_sequencer
// Walks every core of the mesh twice on a go pulse. The first pass issues the
// reset command and the second pass issues the start command with the core's
// entry address. An optional idle gap follows each issued command, and the
// mesh is then parked on the idle opcode.
module mesh_boot_sequencer #(
    parameter int unsigned NUM_CORES   = 16,
    parameter int unsigned ID_BITS     = 4,
    parameter logic [31:0] PROG_BASE   = 32'h10,
    parameter logic [31:0] PROG_STRIDE = 32'h400000,
    parameter int unsigned GAP_CYCLES  = 0,
    parameter logic [3:0]  OP_RESET    = 4'b0011,
    parameter logic [3:0]  OP_START    = 4'b1010,
    parameter logic [3:0]  OP_IDLE     = 4'b0000
) (
    input  logic                 clock,
    input  logic                 RST,
    input  logic                 go,
    input  logic [NUM_CORES-1:0] core_mask,
    output logic [3:0]           operation,
    output logic [ID_BITS-1:0]   core_ID,
    output logic                 ON,
    output logic                 reset,
    output logic                 start,
    output logic [31:0]          prog_address,
    output logic                 issue_valid,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RST_PH,
        S_START_PH,
        S_FINISH
    } state_t;

    localparam logic [ID_BITS-1:0] LAST_IDX = ID_BITS'(NUM_CORES - 1);

    state_t               state_q, state_d;
    logic [ID_BITS-1:0]   idx_q, idx_d;
    logic [7:0]           gap_q, gap_d;
    logic [NUM_CORES-1:0] mask_q, mask_d;

    logic [3:0]           operation_q, operation_d;
    logic [ID_BITS-1:0]   core_id_q, core_id_d;
    logic                 on_q, on_d;
    logic                 reset_q, reset_d;
    logic                 start_q, start_d;
    logic [31:0]          prog_address_q, prog_address_d;
    logic                 issue_valid_q, issue_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Slot processing is shared between the go edge and the two phase states.
    logic                 slot_en;
    logic                 slot_start;
    logic [ID_BITS-1:0]   slot_idx;
    logic [NUM_CORES-1:0] slot_mask;

    // Next-state and registered-output computation.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        gap_d          = gap_q;
        mask_d         = mask_q;
        operation_d    = operation_q;
        core_id_d      = core_id_q;
        on_d           = on_q;
        reset_d        = reset_q;
        start_d        = start_q;
        prog_address_d = prog_address_q;
        issue_valid_d  = 1'b0;
        busy_d         = busy_q;
        done_d         = 1'b0;
        slot_en        = 1'b0;
        slot_start     = 1'b0;
        slot_idx       = idx_q;
        slot_mask      = mask_q;

        case (state_q)
            S_IDLE: begin
                // Core 0 is handled on the accepting edge itself, using the
                // incoming mask because mask_q has not been loaded yet.
                if (go) begin
                    mask_d    = core_mask;
                    busy_d    = 1'b1;
                    slot_en   = 1'b1;
                    slot_idx  = '0;
                    slot_mask = core_mask;
                end
            end
            S_RST_PH, S_START_PH: begin
                slot_start = (state_q == S_START_PH);
                if (gap_q != '0) begin
                    gap_d = gap_q - 8'd1;
                end else begin
                    slot_en = 1'b1;
                end
            end
            S_FINISH: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 8'd1;
                end else begin
                    operation_d = OP_IDLE;
                    reset_d     = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    idx_d       = '0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (slot_en) begin
            if (slot_mask[slot_idx]) begin
                issue_valid_d = 1'b1;
                core_id_d     = slot_idx;
                gap_d         = 8'(GAP_CYCLES);
                if (slot_start) begin
                    operation_d    = OP_START;
                    reset_d        = 1'b0;
                    start_d        = 1'b1;
                    prog_address_d = PROG_BASE + (32'(slot_idx) * PROG_STRIDE);
                end else begin
                    operation_d = OP_RESET;
                    on_d        = 1'b1;
                    reset_d     = 1'b1;
                    start_d     = 1'b0;
                end
            end
            if (slot_idx == LAST_IDX) begin
                idx_d   = '0;
                state_d = slot_start ? S_FINISH : S_START_PH;
            end else begin
                idx_d   = slot_idx + 1'b1;
                state_d = slot_start ? S_START_PH : S_RST_PH;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (RST) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            gap_q          <= '0;
            mask_q         <= '0;
            operation_q    <= '0;
            core_id_q      <= '0;
            on_q           <= 1'b0;
            reset_q        <= 1'b0;
            start_q        <= 1'b0;
            prog_address_q <= '0;
            issue_valid_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            gap_q          <= gap_d;
            mask_q         <= mask_d;
            operation_q    <= operation_d;
            core_id_q      <= core_id_d;
            on_q           <= on_d;
            reset_q        <= reset_d;
            start_q        <= start_d;
            prog_address_q <= prog_address_d;
            issue_valid_q  <= issue_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign operation    = operation_q;
    assign core_ID      = core_id_q;
    assign ON           = on_q;
    assign reset        = reset_q;
    assign start        = start_q;
    assign prog_address = prog_address_q;
    assign issue_valid  = issue_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_mesh_boot_sequencer.sv
// tb_mesh_boot_sequencer
// Two sequencers: dut0 with no gap and dut1 with a two-cycle gap. A schedule
// model builds the expected per-cycle output stream for each accepted go.
module tb_mesh_boot_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i  [2];
    logic        go_i   [2];
    logic [15:0] mask_i [2];
    logic [3:0]  op_w   [2];
    logic [3:0]  id_w   [2];
    logic        on_w   [2];
    logic        rs_w   [2];
    logic        st_w   [2];
    logic [31:0] addr_w [2];
    logic        iv_w   [2];
    logic        busy_w [2];
    logic        done_w [2];

    mesh_boot_sequencer dut0 (
        .clock(clk), .RST(rst_i[0]), .go(go_i[0]), .core_mask(mask_i[0]),
        .operation(op_w[0]), .core_ID(id_w[0]), .ON(on_w[0]), .reset(rs_w[0]),
        .start(st_w[0]), .prog_address(addr_w[0]), .issue_valid(iv_w[0]),
        .busy(busy_w[0]), .done(done_w[0])
    );

    mesh_boot_sequencer #(.GAP_CYCLES(2)) dut1 (
        .clock(clk), .RST(rst_i[1]), .go(go_i[1]), .core_mask(mask_i[1]),
        .operation(op_w[1]), .core_ID(id_w[1]), .ON(on_w[1]), .reset(rs_w[1]),
        .start(st_w[1]), .prog_address(addr_w[1]), .issue_valid(iv_w[1]),
        .busy(busy_w[1]), .done(done_w[1])
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  id;
        logic        on;
        logic        rs;
        logic        st;
        logic [31:0] addr;
        logic        iv;
        logic        busy;
        logic        done;
    } out_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    out_t exp_o [2];
    int   pos   [2];
    out_t sched [2][128];

    function automatic out_t act(input int d);
        out_t o;
        o.op = op_w[d];  o.id = id_w[d];  o.on = on_w[d];  o.rs = rs_w[d];
        o.st = st_w[d];  o.addr = addr_w[d]; o.iv = iv_w[d];
        o.busy = busy_w[d]; o.done = done_w[d];
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    // Expected output stream for one sequence: one entry per cycle after go.
    task automatic build(input int d, input logic [15:0] m);
        out_t cur;
        int   n;
        int   gap;
        gap = (d == 1) ? 2 : 0;
        cur = exp_o[d];
        cur.busy = 1'b1;
        n = 0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 16; i++) begin
                cur.iv = 1'b0;
                if (m[i]) begin
                    cur.iv = 1'b1;
                    cur.id = 4'(i);
                    if (ph == 0) begin
                        cur.op = 4'b0011; cur.on = 1'b1; cur.rs = 1'b1; cur.st = 1'b0;
                    end else begin
                        cur.op = 4'b1010; cur.rs = 1'b0; cur.st = 1'b1;
                        cur.addr = 32'h10 + 32'(i) * 32'h400000;
                    end
                    sched[d][n] = cur; n++;
                    cur.iv = 1'b0;
                    for (int g = 0; g < gap; g++) begin
                        sched[d][n] = cur; n++;
                    end
                end else begin
                    sched[d][n] = cur; n++;
                end
            end
        end
        cur.op = 4'b0000; cur.rs = 1'b0; cur.iv = 1'b0; cur.done = 1'b1; cur.busy = 1'b0;
        sched[d][n] = cur;
    endtask

    task automatic model_step(input int d);
        if (rst_i[d]) begin
            exp_o[d] = '0;
            pos[d]   = -1;
        end else if (pos[d] >= 0) begin
            exp_o[d] = sched[d][pos[d]];
            pos[d]++;
            if (exp_o[d].done) pos[d] = -1;
        end else begin
            exp_o[d].iv   = 1'b0;
            exp_o[d].done = 1'b0;
            if (go_i[d]) begin
                build(d, mask_i[d]);
                exp_o[d] = sched[d][0];
                pos[d]   = 1;
            end
        end
    endtask

    // Compare process: model advances on each rising edge, checked on falling.
    initial begin
        exp_o[0] = '0; exp_o[1] = '0; pos[0] = -1; pos[1] = -1;
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) model_step(d);
            @(negedge clk);
            for (int d = 0; d < 2; d++) chk($sformatf("cycle_dut%0d", d), 64'(act(d)), 64'(exp_o[d]));
        end
    end

    task automatic run_seq(input int d, input logic [15:0] m, input int pulse_at, input bit hold,
                           output int dc, output int ni, output logic [31:0] a15,
                           output logic [31:0] a2, output bit first_ok);
        int cyc;
        @(negedge clk);
        go_i[d] = 1'b1; mask_i[d] = m;
        dc = 0; ni = 0; a15 = '0; a2 = '0; first_ok = 1'b0; cyc = 0;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (!hold) go_i[d] = (cyc == pulse_at);
            if (cyc == 1) first_ok = iv_w[d] && id_w[d] == 4'd0 && op_w[d] == 4'b0011;
            if (iv_w[d]) begin
                ni++;
                if (st_w[d] && id_w[d] == 4'd15) a15 = addr_w[d];
                if (st_w[d] && id_w[d] == 4'd2)  a2  = addr_w[d];
            end
            if (done_w[d]) begin
                dc = cyc;
                break;
            end
        end
    endtask

    initial begin
        int          dc, ni, nd, cnt;
        logic [31:0] a15, a2;
        bit          fok;
        for (int d = 0; d < 2; d++) begin
            rst_i[d] = 1'b1; go_i[d] = 1'b0; mask_i[d] = '0;
        end
        repeat (2) @(negedge clk);
        chk("reset_dut0", 64'(act(0)), 64'd0);
        chk("reset_dut1", 64'(act(1)), 64'd0);
        rst_i[0] = 1'b0; rst_i[1] = 1'b0;
        repeat (2) @(negedge clk);

        // Full mask, no gap
        run_seq(0, 16'hFFFF, 0, 1'b0, dc, ni, a15, a2, fok);
        chk("t1_done_cycle", 64'(dc), 64'd33);
        chk("t1_issues", 64'(ni), 64'd32);
        chk("t1_addr15", 64'(a15), 64'h3C00010);
        chk("t1_first_cmd", 64'(fok), 64'd1);
        @(negedge clk);
        chk("t1_op_idle", 64'(op_w[0]), 64'd0);

        // Sparse mask
        run_seq(0, 16'h0005, 0, 1'b0, dc, ni, a15, a2, fok);
        chk("t2_done_cycle", 64'(dc), 64'd33);
        chk("t2_issues", 64'(ni), 64'd4);
        chk("t2_addr2", 64'(a2), 64'h800010);

        // Empty mask still pulses done on time
        run_seq(0, 16'h0000, 0, 1'b0, dc, ni, a15, a2, fok);
        chk("mask0_done_cycle", 64'(dc), 64'd33);
        chk("mask0_issues", 64'(ni), 64'd0);

        // go re-pulsed while busy is ignored
        run_seq(0, 16'hFFFF, 10, 1'b0, dc, ni, a15, a2, fok);
        chk("t5_done_cycle", 64'(dc), 64'd33);
        chk("t5_issues", 64'(ni), 64'd32);

        // go held high: next sequence starts right after done
        run_seq(0, 16'hFFFF, 0, 1'b1, dc, ni, a15, a2, fok);
        chk("t6_done_cycle", 64'(dc), 64'd33);
        @(negedge clk);
        chk("t6_restart_cmd", 64'({iv_w[0], id_w[0], op_w[0]}), 64'({1'b1, 4'd0, 4'b0011}));
        go_i[0] = 1'b0;
        cnt = 0;
        while (cnt < 200 && !done_w[0]) begin
            @(negedge clk);
            cnt++;
        end
        chk("t6_second_done", 64'(cnt), 64'd32);

        // Reset at START_PH core 5
        @(negedge clk);
        go_i[0] = 1'b1; mask_i[0] = 16'hFFFF;
        @(negedge clk);
        go_i[0] = 1'b0;
        repeat (21) @(negedge clk);
        chk("t4_core5", 64'({id_w[0], st_w[0], iv_w[0]}), 64'({4'd5, 1'b1, 1'b1}));
        rst_i[0] = 1'b1;
        @(negedge clk);
        chk("t4_zeroed", 64'(act(0)), 64'd0);
        rst_i[0] = 1'b0;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_w[0]) nd++;
        end
        chk("t4_no_done", 64'(nd), 64'd0);
        run_seq(0, 16'hFFFF, 0, 1'b0, dc, ni, a15, a2, fok);
        chk("t4_restart_first", 64'(fok), 64'd1);
        chk("t4_restart_done", 64'(dc), 64'd33);

        // Two-cycle gap after every issue
        run_seq(1, 16'hFFFF, 0, 1'b0, dc, ni, a15, a2, fok);
        chk("t3_done_cycle", 64'(dc), 64'd97);
        chk("t3_issues", 64'(ni), 64'd32);
        chk("t3_addr15", 64'(a15), 64'h3C00010);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
